// File: rtl/mem_stream_pkg.sv
// Shared constants and FSM encoding for the memory dump reader.
// Imported by the interface, the FIFO user and the top level.
package mem_stream_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } rd_state_t;

endpackage

// File: rtl/mem_dump_reader_if.sv
// Memory port B read bus plus the outbound ready/valid stream.
// master = reader side, slave = memory + consumer side.
interface mem_dump_reader_if;
  import mem_stream_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_q,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_q,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO, registered head, sync active-low reset.
// Storage resets to zero so dout reads 0 out of reset.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign count  = cnt_q;
  assign dout   = mem_q[rd_q];
  assign do_pop = pop && !empty;

  always_comb begin
    wr_d  = push   ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push)
        mem_q[wr_q] <= din;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// Block reader: issues port B reads under FIFO credit and streams
// the words out in order over a ready/valid link.
module mem_dump_reader
  import mem_stream_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  mem_dump_reader_if.master bus
);

  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [READ_LATENCY-1:0] sr_q, sr_d;

  logic [IW-1:0] inflight;
  logic [FW-1:0] fifo_cnt;
  logic [CW-1:0] used;
  logic          rd;
  logic          push, pop;
  logic          fifo_empty, fifo_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      sr_q     <= sr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = word_count;
          state_d  = (word_count == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (rd) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0 && fifo_empty)
          state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Credit: every in-flight read already owns a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      inflight = inflight + IW'(sr_q[i]);
    used = CW'(inflight) + CW'(fifo_cnt);
    rd   = (state_q == ISSUE) &&
           (used < CW'(FIFO_DEPTH));
    busy = (state_q != IDLE);
    done = (state_q == FINISH);
  end

  always_comb begin
    sr_d[0] = rd;
    for (int i = 1; i < READ_LATENCY; i++)
      sr_d[i] = sr_q[i-1];
  end

  assign push = sr_q[READ_LATENCY-1];
  assign pop  = !fifo_empty && bus.out_ready;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.mem_q),
    .dout  (bus.out_data),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd    = rd;
  assign bus.out_valid = !fifo_empty;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
      !(push && fifo_full)
  ) else $error("mem_dump_reader fifo overflow");

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table of transfers on a latency-1 DUT,
// corner sequences, and a latency-3 stall case.
module tb_mem_dump_reader;

  localparam int MASK = 32'hFFFFF;

  typedef struct {
    int base;
    int count;
    int mode;
    int glitch;
  } vec_t;

  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  logic        start1 = 0, start3 = 0;
  logic [19:0] base1 = 0, base3 = 0;
  logic [19:0] cnt1 = 0, cnt3 = 0;
  logic        busy1, done1, busy3, done3;

  mem_dump_reader_if bus1 ();
  mem_dump_reader_if bus3 ();

  mem_dump_reader #(.READ_LATENCY(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .base_addr(base1), .word_count(cnt1),
    .busy(busy1), .done(done1), .bus(bus1)
  );

  mem_dump_reader #(.READ_LATENCY(3), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .start(start3),
    .base_addr(base3), .word_count(cnt3),
    .busy(busy3), .done(done3), .bus(bus3)
  );

  logic [15:0] mem [0:(1<<20)-1];
  logic [15:0] q1;
  logic [15:0] p3 [3];

  always @(posedge clk) begin
    q1    <= mem[bus1.mem_addr];
    p3[0] <= mem[bus3.mem_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.mem_q = q1;
  assign bus3.mem_q = p3[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input bit ok, input int act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual %0d outside required range", nm, act);
    end
  endtask

  int cyc1 = 0, fv1 = -1, out1 = 0, hold1 = 0;
  bit stall1 = 0, pdone1 = 0;
  int rx1[$], rxc1[$], ad1[$], dn1[$];

  always @(negedge clk) begin
    if (!rst) begin
      out1 = 0; stall1 = 0; pdone1 = 0;
    end else begin
      if (bus1.mem_rd) begin
        chkb("credit1", out1 < 4, out1);
        ad1.push_back(int'(bus1.mem_addr));
      end
      if (stall1) begin
        chk("stall_valid1", int'(bus1.out_valid), 1);
        chk("stall_data1", int'(bus1.out_data), hold1);
      end
      if (bus1.out_valid && fv1 < 0) fv1 = cyc1;
      if (bus1.out_valid && bus1.out_ready) begin
        rx1.push_back(int'(bus1.out_data));
        rxc1.push_back(cyc1);
      end
      if (done1) begin
        dn1.push_back(cyc1);
        chk("busy_at_done1", int'(busy1), 1);
      end
      if (pdone1) chk("busy_after_done1", int'(busy1), 0);
      out1 = out1 + int'(bus1.mem_rd)
           - int'(bus1.out_valid && bus1.out_ready);
      stall1 = bus1.out_valid && !bus1.out_ready;
      hold1  = int'(bus1.out_data);
      pdone1 = done1;
    end
    cyc1++;
  end

  int out3 = 0, hold3 = 0;
  bit stall3 = 0;
  int rx3[$], ad3[$], dn3[$];

  always @(negedge clk) begin
    if (!rst) begin
      out3 = 0; stall3 = 0;
    end else begin
      if (bus3.mem_rd) begin
        chkb("credit3", out3 < 4, out3);
        ad3.push_back(int'(bus3.mem_addr));
      end
      if (stall3)
        chk("stall_data3", int'(bus3.out_data), hold3);
      if (bus3.out_valid && bus3.out_ready)
        rx3.push_back(int'(bus3.out_data));
      if (done3) dn3.push_back(1);
      out3 = out3 + int'(bus3.mem_rd)
           - int'(bus3.out_valid && bus3.out_ready);
      stall3 = bus3.out_valid && !bus3.out_ready;
      hold3  = int'(bus3.out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[3 - (c % 4)];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic xfer(input vec_t v);
    int c, st, lat;
    rx1.delete(); rxc1.delete();
    ad1.delete(); dn1.delete();
    fv1 = -1;
    st = cyc1;
    start1 = 1;
    base1 = 20'(v.base);
    cnt1 = 20'(v.count);
    c = 0;
    while (dn1.size() == 0 && c < 300) begin
      bus1.out_ready = rdy(v.mode, c);
      if (c == v.glitch) begin
        start1 = 1;
        base1 = 20'd5000;
        cnt1 = 20'd2;
      end
      tick();
      start1 = 0;
      c++;
    end
    if (dn1.size() == 0) chk("done_timeout", c, -1);
    bus1.out_ready = 1;
    repeat (2) tick();
    chk("done_pulses", dn1.size(), 1);
    chk("nwords", rx1.size(), v.count);
    for (int i = 0; i < rx1.size() && i < v.count; i++)
      chk("word", rx1[i], int'(mem[(v.base + i) & MASK]));
    chk("nreads", ad1.size(), v.count);
    for (int i = 0; i < ad1.size() && i < v.count; i++)
      chk("addr", ad1[i], (v.base + i) & MASK);
    if (v.count == 0) begin
      chk("zero_novalid", fv1, -1);
      lat = (dn1.size() > 0) ? dn1[0] - st : -1;
      chkb("zero_done_lat", lat >= 1 && lat <= 2, lat);
    end else if (v.mode == 0) begin
      chk("first_valid", fv1 - st, 3);
      for (int i = 0; i < rxc1.size(); i++)
        chk("back_to_back", rxc1[i] - rxc1[0], i);
    end
  endtask

  vec_t tv [10];
  int c3;

  initial begin
    for (int i = 0; i < (1 << 20); i++)
      mem[i] = 16'($urandom);
    mem[100] = 16'h1111;
    mem[101] = 16'h2222;
    mem[102] = 16'h3333;
    mem[103] = 16'h4444;

    tv[0] = '{100, 4, 0, -1};
    tv[1] = '{0, 8, 1, -1};
    tv[2] = '{0, 0, 0, -1};
    tv[3] = '{32'hFFFFE, 4, 0, -1};
    tv[4] = '{200, 6, 0, 2};
    tv[9] = '{32'hFFFF0, 20, 1, -1};
    for (int i = 5; i < 9; i++)
      tv[i] = '{int'($urandom) & MASK,
                int'($urandom_range(1, 12)), 2, -1};

    bus1.out_ready = 0;
    bus3.out_ready = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_rd", int'(bus1.mem_rd), 0);
    chk("rst_valid", int'(bus1.out_valid), 0);
    chk("rst_addr", int'(bus1.mem_addr), 0);
    chk("rst_data", int'(bus1.out_data), 0);
    chk("rst_busy3", int'(busy3), 0);
    chk("rst_valid3", int'(bus3.out_valid), 0);
    rst = 1;
    tick();
    tick();

    for (int i = 0; i < 10; i++)
      xfer(tv[i]);

    rx1.delete(); ad1.delete(); dn1.delete();
    start1 = 1;
    base1 = 20'd300;
    cnt1 = 20'd8;
    bus1.out_ready = 0;
    tick();
    start1 = 0;
    repeat (4) tick();
    chk("pre_rst_reads", ad1.size(), 4);
    rst = 0;
    tick();
    rst = 1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy1), 0);
    chk("mid_rst_done", int'(done1), 0);
    chk("mid_rst_rd", int'(bus1.mem_rd), 0);
    chk("mid_rst_valid", int'(bus1.out_valid), 0);
    chk("mid_rst_addr", int'(bus1.mem_addr), 0);
    chk("mid_rst_data", int'(bus1.out_data), 0);
    tick();
    bus1.out_ready = 1;
    repeat (10) tick();
    chk("mid_rst_nodone", dn1.size(), 0);
    chk("mid_rst_nowords", rx1.size(), 0);
    chk("mid_rst_noreads", ad1.size(), 4);
    xfer('{400, 5, 0, -1});

    start3 = 1;
    base3 = 20'd1000;
    cnt3 = 20'd8;
    bus3.out_ready = 0;
    tick();
    start3 = 0;
    repeat (11) tick();
    chk("rl3_stall_reads", ad3.size(), 4);
    chk("rl3_stall_words", rx3.size(), 0);
    bus3.out_ready = 1;
    c3 = 0;
    while (dn3.size() == 0 && c3 < 100) begin
      tick();
      c3++;
    end
    chk("rl3_done", dn3.size(), 1);
    chk("rl3_nwords", rx3.size(), 8);
    chk("rl3_nreads", ad3.size(), 8);
    for (int i = 0; i < rx3.size() && i < 8; i++)
      chk("rl3_word", rx3[i], int'(mem[1000 + i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
